// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults for the FIFO controller.
//   ADDR_W_DEF  RAM address width
//   DATA_W_DEF  data width
//   DEPTH_DEF   entries, 2**ADDR_W_DEF
//   CNT_W_DEF   occupancy counter width (must hold 0..DEPTH)
package fifo_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;
   localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

   // Occupancy register width for a given address width; one extra bit so
   // that a completely full FIFO (count == DEPTH) is representable.
   function automatic int cnt_width(input int addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/count controller for a FIFO built around an external
// dual-port RAM with a registered read port (1-cycle read latency). The RAM
// is instantiated beside this block by the integrator.
//
// Ports
//   clk, reset     clock; asynchronous active-high reset
//   wr_en/wr_data  push request and data
//   rd_en          pop request
//   rd_data        popped data (valid while rd_valid=1), straight from ram_dout
//   rd_valid       high the cycle after an accepted pop
//   full/empty     registered occupancy flags
//   count          occupancy 0..DEPTH
//   ram_we/ram_we_addr/ram_din   RAM write port
//   ram_re/ram_re_addr           RAM read port
//   ram_dout       RAM registered read data
//   overflow/underflow  sticky error flags
//
// Build option
//   FIFO_ERR_FLAG_EN  when defined, overflow/underflow are live sticky flags;
//                     otherwise both outputs are tied to 0.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_we_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_re,
   output logic [ADDR_W-1:0] ram_re_addr,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              overflow,
   output logic              underflow
);

   localparam int CNT_W = cnt_width(ADDR_W);

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_full;
   logic              r_empty;
   logic              r_rd_valid;

   logic              w_push_acc;
   logic              w_pop_acc;
   logic [CNT_W-1:0]  w_count_nxt;

   // Acceptance uses the registered flags only. Because a pop needs a
   // non-empty FIFO and a push a non-full one, read and write addresses can
   // only coincide when count is 0 or DEPTH, so they never collide.
   // Reset gates both so the RAM sees no strobes while reset is held.
   assign w_push_acc = wr_en & ~r_full  & ~reset;
   assign w_pop_acc  = rd_en & ~r_empty & ~reset;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push_acc, w_pop_acc})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Pointers are exactly ADDR_W bits wide, so DEPTH-1 -> 0 wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_rd_valid <= 1'b0;
      end else begin
         if (w_push_acc) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_pop_acc) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
         r_count    <= w_count_nxt;
         r_full     <= (w_count_nxt == CNT_W'(DEPTH));
         r_empty    <= (w_count_nxt == '0);
         r_rd_valid <= w_pop_acc;
      end
   end

`ifdef FIFO_ERR_FLAG_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky until reset. Overflow: push attempted while full (a full FIFO
   // never accepts a push, even alongside a pop). Underflow: pop attempted
   // while empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (wr_en && r_full && !w_push_acc) begin
            r_overflow <= 1'b1;
         end
         if (rd_en && r_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

   assign ram_we      = w_push_acc;
   assign ram_we_addr = r_wr_ptr;
   assign ram_din     = wr_data;
   assign ram_re      = w_pop_acc;
   assign ram_re_addr = r_rd_ptr;

   assign rd_data  = ram_dout;
   assign rd_valid = r_rd_valid;
   assign count    = r_count;
   assign full     = r_full;
   assign empty    = r_empty;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: self-checking bench for fifo_ctrl. A queue-based FIFO model
// predicts every output; a compare process checks it each negedge. Directed
// sections pin the model with literal expectations, then a randomized phase
// with varying push/pop bias and occasional async resets follows.
// Honours FIFO_ERR_FLAG_EN for the overflow/underflow expectations.
module tb_fifo_ctrl;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int DP = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          ram_we;
   logic [AW-1:0] ram_we_addr;
   logic [DW-1:0] ram_din;
   logic          ram_re;
   logic [AW-1:0] ram_re_addr;
   logic [DW-1:0] ram_dout = '0;
   logic          overflow;
   logic          underflow;

   int n_vec = 0;
   int n_err = 0;

   fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .full(full), .empty(empty), .count(count),
      .ram_we(ram_we), .ram_we_addr(ram_we_addr), .ram_din(ram_din),
      .ram_re(ram_re), .ram_re_addr(ram_re_addr), .ram_dout(ram_dout),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // External dual-port RAM with registered read.
   logic [DW-1:0] mem [DP];
   always @(posedge clk) begin
      if (ram_we) mem[ram_we_addr] <= ram_din;
      if (ram_re) ram_dout <= mem[ram_re_addr];
   end

`ifdef FIFO_ERR_FLAG_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: contents as a queue, addresses as running op counts.
   logic [DW-1:0] m_q[$];
   int            m_pushes = 0;
   int            m_pops = 0;
   bit            m_rvalid = 0;
   logic [DW-1:0] m_rdata = '0;
   bit            m_ovf = 0;
   bit            m_udf = 0;

   always @(posedge clk) begin
      int sz;
      bit psh, pop;
      sz = m_q.size();
      if (reset) begin
         m_q.delete();
         m_pushes = 0;
         m_pops   = 0;
         m_rvalid = 0;
         m_ovf    = 0;
         m_udf    = 0;
      end else begin
         psh = wr_en && (sz < DP);
         pop = rd_en && (sz > 0);
         if (ERR_EN && wr_en && sz == DP) m_ovf = 1;
         if (ERR_EN && rd_en && sz == 0)  m_udf = 1;
         m_rvalid = pop;
         if (pop) begin
            m_rdata = m_q.pop_front();
            m_pops++;
         end
         if (psh) begin
            m_q.push_back(wr_data);
            m_pushes++;
         end
      end
   end

   always @(negedge clk) begin
      int sz;
      bit e_we, e_re;
      sz = m_q.size();
      if (reset) begin
         chk("rst_count", 32'(count), 0);
         chk("rst_empty", 32'(empty), 1);
         chk("rst_full", 32'(full), 0);
         chk("rst_rd_valid", 32'(rd_valid), 0);
         chk("rst_ram_we", 32'(ram_we), 0);
         chk("rst_ram_re", 32'(ram_re), 0);
         chk("rst_overflow", 32'(overflow), 0);
         chk("rst_underflow", 32'(underflow), 0);
      end else begin
         e_we = wr_en && (sz < DP);
         e_re = rd_en && (sz > 0);
         chk("count", 32'(count), 32'(sz));
         chk("full", 32'(full), 32'(sz == DP));
         chk("empty", 32'(empty), 32'(sz == 0));
         chk("rd_valid", 32'(rd_valid), 32'(m_rvalid));
         if (m_rvalid) chk("rd_data", 32'(rd_data), 32'(m_rdata));
         chk("ram_we", 32'(ram_we), 32'(e_we));
         if (e_we) begin
            chk("ram_we_addr", 32'(ram_we_addr), 32'(m_pushes % DP));
            chk("ram_din", 32'(ram_din), 32'(wr_data));
         end
         chk("ram_re", 32'(ram_re), 32'(e_re));
         if (e_re) chk("ram_re_addr", 32'(ram_re_addr), 32'(m_pops % DP));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("underflow", 32'(underflow), 32'(m_udf));
      end
   end

   // Stimulus helpers: inputs change 2 time units after a rising edge.
   task automatic drive(input logic w, input logic r, input logic [DW-1:0] d);
      wr_en = w; rd_en = r; wr_data = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_reset();
      drive(0, 0, 0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int pw, pr;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;

      // First push after reset.
      drive(1, 0, 8'hA1);
      #1;
      chk("first_we", 32'(ram_we), 1);
      chk("first_we_addr", 32'(ram_we_addr), 0);
      tick();
      drive(0, 0, 0);
      #1;
      chk("first_count", 32'(count), 1);
      chk("first_empty", 32'(empty), 0);

      // Fill to full, then one push too many.
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1, 0, 8'(i));
         tick();
      end
      drive(0, 0, 0);
      #1;
      chk("fill_count", 32'(count), 16);
      chk("fill_full", 32'(full), 1);
      drive(1, 0, 8'hEE);
      #1;
      chk("over_we", 32'(ram_we), 0);
      tick();
      drive(0, 0, 0);
      #1;
      chk("overflow_flag", 32'(overflow), 32'(ERR_EN));
      chk("over_count", 32'(count), 16);

      // Drain: data back in order, one cycle after each pop.
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 0);
         tick();
         #1;
         chk("drain_valid", 32'(rd_valid), 1);
         chk("drain_data", 32'(rd_data), 32'(i));
      end
      drive(0, 0, 0);
      tick();
      #1;
      chk("drain_empty", 32'(empty), 1);
      chk("drain_valid_off", 32'(rd_valid), 0);
      drive(0, 1, 0);
      #1;
      chk("under_re", 32'(ram_re), 0);
      tick();
      drive(0, 0, 0);
      #1;
      chk("underflow_flag", 32'(underflow), 32'(ERR_EN));

      // Pointer wrap through 20 push/pop pairs.
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 8'(8'h40 + i));
         #1;
         chk("wrap_we_addr", 32'(ram_we_addr), 32'(i % 16));
         tick();
         drive(0, 1, 0);
         tick();
         #1;
         chk("wrap_data", 32'(rd_data), 32'(8'h40 + i));
         chk("wrap_count", 32'(count), 0);
      end

      // Simultaneous push/pop at full, empty and mid-level.
      for (int i = 0; i < 16; i++) begin
         drive(1, 0, 8'(8'h80 + i));
         tick();
      end
      drive(1, 1, 8'h99);
      tick();
      drive(0, 0, 0);
      #1;
      chk("both_full_count", 32'(count), 15);
      chk("both_full_data", 32'(rd_data), 32'h80);
      for (int i = 0; i < 15; i++) begin
         drive(0, 1, 0);
         tick();
      end
      drive(1, 1, 8'h77);
      tick();
      drive(0, 0, 0);
      #1;
      chk("both_empty_count", 32'(count), 1);
      chk("both_empty_valid", 32'(rd_valid), 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 8'(8'h60 + i));
         tick();
      end
      drive(1, 1, 8'h55);
      tick();
      drive(0, 0, 0);
      #1;
      chk("both_mid_count", 32'(count), 5);
      chk("both_mid_data", 32'(rd_data), 32'h77);

      // Async reset between edges with a pop outstanding.
      drive(1, 0, 8'h11);
      tick();
      drive(1, 0, 8'h12);
      tick();
      drive(0, 1, 0);
      tick();
      drive(0, 0, 0);
      #1;
      chk("pre_rst_count", 32'(count), 6);
      chk("pre_rst_valid", 32'(rd_valid), 1);
      reset = 1'b1;
      #1;
      chk("async_count", 32'(count), 0);
      chk("async_valid", 32'(rd_valid), 0);
      chk("async_empty", 32'(empty), 1);
      chk("async_full", 32'(full), 0);
      chk("async_overflow", 32'(overflow), 0);
      chk("async_underflow", 32'(underflow), 0);
      tick();
      tick();
      reset = 1'b0;

      // Randomized traffic with shifting push/pop bias.
      pw = 50;
      pr = 50;
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) begin
            pw = int'($urandom_range(10, 90));
            pr = int'($urandom_range(10, 90));
         end
         drive(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
               8'($urandom));
         if ($urandom_range(0, 599) == 0) begin
            #1;
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end else begin
            tick();
         end
      end

      drive(0, 0, 0);
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
